mem_access_unit: RTL
====================

# mem_access_unit

Parametrised load/store engine between the core's memory stage and a narrow external memory port. It accepts one load or store per `start` pulse (RISC-V FUNCT3 encoding) and splits it into aligned beats of `BEAT_BYTES` bytes with per-byte enables. It assembles little-endian read data and sign/zero-extends it, then signals completion with a one-cycle `done`. It supersedes the fixed 32-bit, byte-serial memory controller and adds wider beats, memory wait states, byte enables, 64-bit support and error reporting.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: register width; 32 or 64.
- `BEAT_BYTES`, default 1: bytes per memory transfer; power of 2, 1..`DATA_WIDTH`/8.

Ports:
- `clk`, input, 1: system clock; all logic on posedge.
- `rst`, input, 1: synchronous, active-low reset.
- `start`, input, 1: request; sampled only when idle.
- `address`, input, `ADDR_WIDTH`: byte address of the access.
- `mode`, input, 3: FUNCT3. `[1:0]` size (0=B, 1=H, 2=W, 3=D); `[2]`=1 means unsigned load.
- `write_enable`, input, 1: 1 = store, 0 = load.
- `write_data`, input, `DATA_WIDTH`: store data, LSB-aligned.
- `done`, output, 1: one-cycle completion pulse.
- `err`, output, 1: valid with `done`; access rejected.
- `read_data`, output, `DATA_WIDTH`: extended load result; held until next accepted `start`.
- `active`, output, 1: operation in progress.
- `mem_req`, output, 1: beat request; registered.
- `mem_addr`, output, `ADDR_WIDTH`: beat address, aligned to `BEAT_BYTES`.
- `mem_we`, output, 1: beat is a write.
- `mem_be`, output, `BEAT_BYTES`: byte enables.
- `mem_wdata`, output, 8×`BEAT_BYTES`: beat write data in lane positions.
- `mem_rdata`, input, 8×`BEAT_BYTES`: beat read data; valid when `mem_req && mem_ready`.
- `mem_ready`, input, 1: beat completes on a posedge where `mem_req && mem_ready`.

## Operation
- FSM states: IDLE, BEAT, FINISH.
- IDLE + `start`: latch `address`, `mode`, `write_enable` and `write_data`; compute `nbytes = 1<<mode[1:0]`.
- IDLE + `start`, size error (`8*nbytes > DATA_WIDTH`): go to FINISH with `err=1`. No memory beat is issued.
- IDLE + `start`, no error: go to BEAT.
- Beat count = ceil(((`address` mod `BEAT_BYTES`) + `nbytes`) / `BEAT_BYTES`).
- Beat k address = (`address` & ~(`BEAT_BYTES`−1)) + k·`BEAT_BYTES`. Beats are issued in ascending address order.
- `mem_be` enables only lanes whose byte falls inside [`address`, `address`+`nbytes`−1].
- Stores: byte i of `write_data` goes to the lane of `address`+i. Disabled lanes are driven 0.
- Loads: enabled lanes are stored at position i of an assembly register (little-endian).
- Extension, applied in FINISH: sign-extend from bit 8·`nbytes`−1 when `mode[2]`=0, else zero-extend. Full-width loads are unchanged.
- BEAT advances on each completed beat. After the last beat it goes to FINISH.
- FINISH: `done`=1 for one cycle, update `read_data` (loads only; stores leave it unchanged), then return to IDLE.
- `start` while not IDLE is ignored.
- Address arithmetic wraps modulo 2^`ADDR_WIDTH`.

## Timing
- Reset values: `done`=0, `err`=0, `active`=0, `read_data`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0; FSM in IDLE.
- Reset asserted mid-operation aborts at the next posedge: no `done`, outputs return to reset values, and an in-flight beat is dropped.
- Edge 0 samples `start`. `active` and `mem_req` are high from cycle 1.
- Each beat holds `mem_req`/addr/be/wdata stable until `mem_ready`.
- Consecutive beats are back-to-back, with no idle cycle between them.
- Zero wait states: `done` is high in cycle B+1, where B = beat count. Each wait cycle adds 1.
- `active` drops in the same cycle `done` rises.
- A new `start` is accepted in the `done` cycle's following IDLE cycle, i.e. earliest cycle B+2.
- Error path: `done`=`err`=1 in cycle 1, and `active` never rises.

## Configuration
- `MEMCTL_MISALIGN_TRAP_EN` defined: if `address` mod `nbytes` ≠ 0, the access is rejected exactly like a size error. The response is `done`+`err` in cycle 1, no beats, and `read_data` unchanged.
- Undefined: misaligned accesses are legal and are executed as multiple beats per the rules above.

## Test plan
- `BEAT_BYTES`=1: memory holds bytes 0x80,0x11,0x22,0x33 at 0x100..0x103. LW 0x100 gives `read_data`=0x33221180 after 4 beats, `done` in cycle 5. LB 0x100 gives 0xFFFFFF80; LBU 0x100 gives 0x00000080.
- `BEAT_BYTES`=4: SH 0x102 with data 0xABCD issues one beat at `mem_addr`=0x100, `mem_be`=4'b1100, `mem_wdata`=0xABCD0000.
- `BEAT_BYTES`=4, macro undefined: LW 0x103 issues 2 beats at 0x100 (be 1000) then 0x104 (be 0111), and assembles the result correctly. With the macro defined: `done`+`err` in cycle 1 and `mem_req` never asserted.
- `mem_ready` held low for 3 cycles on beat 0 of LH: `mem_addr`/`mem_be` stay stable, `done` is delayed by exactly 3 cycles, and `start` pulses during busy are ignored.
- `DATA_WIDTH`=32, `mode`=3'b011: `done`=`err`=1 in cycle 1, no beats. `DATA_WIDTH`=64 LD: 8-byte result, no extension.
- Assert `rst`=0 during beat 2 of LW: next cycle `mem_req`=0, `active`=0, no `done` pulse, `read_data`=0.

Source files
------------

// File: rtl/mem_access_if.sv
// Narrow external memory port of mem_access_unit.
interface mem_access_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_BYTES = 1
);
    // Handshake: a beat is offered while mem_req is high, with mem_addr/mem_we/mem_be/mem_wdata
    // held stable; it completes on the posedge where mem_req && mem_ready, and mem_rdata is valid then.
    logic                    mem_req;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_we;
    logic [BEAT_BYTES-1:0]   mem_be;
    logic [8*BEAT_BYTES-1:0] mem_wdata;
    logic [8*BEAT_BYTES-1:0] mem_rdata;
    logic                    mem_ready;

    modport master (
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store engine: splits one access into aligned beats, assembles and extends loads.
// Define MEMCTL_MISALIGN_TRAP_EN to reject accesses not aligned to their own size.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEAT_BYTES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [2:0]            mode,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  active,
    output logic [1:0]            fsm_state,
    mem_access_if.master          mem
);

    localparam int DBYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BEAT_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_STEP = ADDR_WIDTH'(BEAT_BYTES);

    typedef enum logic [1:0] {IDLE = 2'd0, BEAT = 2'd1, FINISH = 2'd2} state_t;

    state_t                state;
    logic [1:0]            size_r;
    logic                  uns_r;
    logic                  we_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] asm_r;
    logic [3:0]            off_r;
    logic [3:0]            beat_idx;
    logic [3:0]            last_idx;

    int                    nb_in;
    int                    off_in;
    int                    nbeats_in;
    logic                  size_err;
    logic                  misalign;
    logic [DATA_WIDTH-1:0] merged;

    assign fsm_state = state;

    // Byte p of the access sits in lane j of beat k where p = k*BEAT_BYTES + j - offset.
    function automatic logic [BEAT_BYTES-1:0] lane_en(input int off, input int size, input int k);
        int p;
        lane_en = '0;
        for (int j = 0; j < BEAT_BYTES; j++) begin
            p = k * BEAT_BYTES + j - off;
            lane_en[j] = (p >= 0) && (p < (1 << size));
        end
    endfunction

    function automatic logic [8*BEAT_BYTES-1:0] lane_data(input logic [DATA_WIDTH-1:0] wd,
                                                         input int off, input int size, input int k);
        int p;
        logic [DATA_WIDTH-1:0] sh;
        lane_data = '0;
        for (int j = 0; j < BEAT_BYTES; j++) begin
            p = k * BEAT_BYTES + j - off;
            if ((p >= 0) && (p < (1 << size))) begin
                sh = wd >> (8 * p);
                lane_data[8*j +: 8] = sh[7:0];
            end
        end
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] cur,
                                                          input logic [8*BEAT_BYTES-1:0] rd,
                                                          input int off, input int size, input int k);
        merge_bytes = cur;
        for (int i = 0; i < DBYTES; i++) begin
            for (int j = 0; j < BEAT_BYTES; j++) begin
                if ((k * BEAT_BYTES + j - off == i) && (i < (1 << size)))
                    merge_bytes[8*i +: 8] = rd[8*j +: 8];
            end
        end
    endfunction

    // Shift the loaded value to the top, then shift back arithmetically or logically.
    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                     input int size, input logic uns);
        int sh;
        logic [DATA_WIDTH-1:0] t;
        sh = DATA_WIDTH - 8 * (1 << size);
        t  = v << sh;
        if (uns) extend = t >> sh;
        else     extend = DATA_WIDTH'($signed(t) >>> sh);
    endfunction

    always_comb begin
        nb_in     = 1 << mode[1:0];
        off_in    = int'(32'(address & OFF_MASK));
        nbeats_in = (off_in + nb_in + BEAT_BYTES - 1) / BEAT_BYTES;
        size_err  = (8 * nb_in) > DATA_WIDTH;
`ifdef MEMCTL_MISALIGN_TRAP_EN
        misalign  = (address & ADDR_WIDTH'(nb_in - 1)) != '0;
`else
        misalign  = 1'b0;
`endif
        merged    = merge_bytes(asm_r, mem.mem_rdata, int'(off_r), int'(size_r), int'(beat_idx));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            done          <= 1'b0;
            err           <= 1'b0;
            active        <= 1'b0;
            read_data     <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
            size_r        <= '0;
            uns_r         <= 1'b0;
            we_r          <= 1'b0;
            wdata_r       <= '0;
            asm_r         <= '0;
            off_r         <= '0;
            beat_idx      <= '0;
            last_idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        size_r   <= mode[1:0];
                        uns_r    <= mode[2];
                        we_r     <= write_enable;
                        wdata_r  <= write_data;
                        off_r    <= 4'(off_in);
                        last_idx <= 4'(nbeats_in - 1);
                        beat_idx <= '0;
                        asm_r    <= '0;
                        if (size_err || misalign) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state         <= BEAT;
                            active        <= 1'b1;
                            mem.mem_req   <= 1'b1;
                            mem.mem_addr  <= address & ~OFF_MASK;
                            mem.mem_we    <= write_enable;
                            mem.mem_be    <= lane_en(off_in, int'(mode[1:0]), 0);
                            mem.mem_wdata <= write_enable ?
                                             lane_data(write_data, off_in, int'(mode[1:0]), 0) : '0;
                        end
                    end
                end
                BEAT: begin
                    if (mem.mem_ready) begin
                        if (!we_r) asm_r <= merged;
                        if (beat_idx == last_idx) begin
                            state         <= FINISH;
                            done          <= 1'b1;
                            active        <= 1'b0;
                            mem.mem_req   <= 1'b0;
                            mem.mem_we    <= 1'b0;
                            mem.mem_be    <= '0;
                            mem.mem_wdata <= '0;
                            if (!we_r) read_data <= extend(merged, int'(size_r), uns_r);
                        end else begin
                            beat_idx      <= beat_idx + 4'd1;
                            mem.mem_addr  <= mem.mem_addr + BEAT_STEP;
                            mem.mem_be    <= lane_en(int'(off_r), int'(size_r), int'(beat_idx) + 1);
                            mem.mem_wdata <= we_r ?
                                             lane_data(wdata_r, int'(off_r), int'(size_r),
                                                       int'(beat_idx) + 1) : '0;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
